pipe_stage_track: RTL and testbench

//   Tracks the instruction word and bubble flag held in each of the ID, EX, MEM and
//   WB pipeline slots of the 5-stage CPU.

---
 rtl/pipe_stage_track_pkg.sv | 43 ++++
 rtl/pipe_stage_track_slot.sv | 49 ++++
 rtl/pipe_stage_track.sv | 125 ++++++++++++
 tb/tb_pipe_stage_track.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_track_pkg.sv
// ---------------------------------------------------------------------------
// pipe_stage_track_pkg
//   Shared types and constants for the pipeline-slot tracker.
//   - NOP_WORD_DEFAULT : instruction word a bubble slot carries.
//   - stage_e          : ID/EX/MEM/WB slot indices. The debug display uses
//                        these to select a stage.
//   - slot_t           : one {inst, bubble} pipeline slot.
//   - slot_ctrl_t      : per-slot load/hold/squash controls.
// ---------------------------------------------------------------------------
package pipe_stage_track_pkg;

  localparam int INST_W     = 32;
  localparam int NUM_STAGES = 4;

  localparam logic [INST_W-1:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    STAGE_ID  = 2'd0,
    STAGE_EX  = 2'd1,
    STAGE_MEM = 2'd2,
    STAGE_WB  = 2'd3
  } stage_e;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic              bubble;
  } slot_t;

  typedef struct packed {
    logic ld;
    logic hold;
    logic squash;
  } slot_ctrl_t;

  // Canonical bubble contents for a given NOP encoding.
  function automatic slot_t bubble_slot(input logic [INST_W-1:0] nop);
    slot_t s;
    s.inst   = nop;
    s.bubble = 1'b1;
    return s;
  endfunction

endpackage

// File: rtl/pipe_stage_track_slot.sv
// ---------------------------------------------------------------------------
// pipe_slot
//   One {inst, bubble} pipeline register. Its control priority is
//   rst > squash > hold > ld. When no control is asserted, the register keeps
//   its value.
// Ports
//   i_clk    : clock (rising edge)
//   i_rst    : synchronous active-high reset. Loads a bubble.
//   i_ld     : load i_d
//   i_hold   : keep the current contents
//   i_squash : load a bubble
//   i_d      : incoming slot contents
//   o_q      : registered slot contents
// ---------------------------------------------------------------------------
module pipe_slot
  import pipe_stage_track_pkg::*;
#(
  parameter logic [INST_W-1:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic  i_clk,
  input  logic  i_rst,
  input  logic  i_ld,
  input  logic  i_hold,
  input  logic  i_squash,
  input  slot_t i_d,
  output slot_t o_q
);

  slot_t r_q;

  // NOTE: sequential state uses non-blocking assignments only. Every flop
  // then samples pre-edge values, whatever order the blocks evaluate in.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= bubble_slot(NOP_WORD);
    end else if (i_squash) begin
      r_q <= bubble_slot(NOP_WORD);
    end else if (i_hold) begin
      r_q <= r_q;
    end else if (i_ld) begin
      // A bubble never carries a stray word. IF may present garbage when
      // its valid signal is low.
      r_q <= i_d.bubble ? bubble_slot(NOP_WORD) : i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_track.sv
// ---------------------------------------------------------------------------
// pipe_stage_track
//   Shadows the instruction word and bubble flag in the ID/EX/MEM/WB slots of
//   the 5-stage CPU. It applies the same stall/flush/freeze controls as the
//   datapath, and it counts cycles, retired instructions and WB bubbles.
// Ports
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_if_inst, i_if_valid   : IF-stage word and its valid flag
//   i_stall                 : load-use stall (hold ID, bubble into EX)
//   i_flush                 : taken branch (squash ID and EX)
//   i_freeze                : debug halt (everything holds)
//   o_<stage>_inst/_bubble  : registered slot contents, stage = id/ex/mem/wb
//   o_retire                : combinational, a real instruction leaves WB
//   o_cycle_cnt             : non-frozen cycles since reset
//   o_retire_cnt            : real instructions that left WB
//   o_bubble_cnt            : WB cycles that held a bubble
// ---------------------------------------------------------------------------
module pipe_stage_track
  import pipe_stage_track_pkg::*;
#(
  parameter int                CNT_W    = 32,
  parameter logic [INST_W-1:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [INST_W-1:0] i_if_inst,
  input  logic              i_if_valid,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic              i_freeze,
  output logic [INST_W-1:0] o_id_inst,
  output logic              o_id_bubble,
  output logic [INST_W-1:0] o_ex_inst,
  output logic              o_ex_bubble,
  output logic [INST_W-1:0] o_mem_inst,
  output logic              o_mem_bubble,
  output logic [INST_W-1:0] o_wb_inst,
  output logic              o_wb_bubble,
  output logic              o_retire,
  output logic [CNT_W-1:0]  o_cycle_cnt,
  output logic [CNT_W-1:0]  o_retire_cnt,
  output logic [CNT_W-1:0]  o_bubble_cnt
);

  slot_ctrl_t w_ctrl [NUM_STAGES];
  slot_t      w_d    [NUM_STAGES];
  slot_t      w_q    [NUM_STAGES];

  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_retire_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;

  // Each slot's data input is its upstream neighbour. The ID slot takes IF.
  always_comb begin
    w_d[STAGE_ID].inst   = i_if_inst;
    w_d[STAGE_ID].bubble = ~i_if_valid;
    w_d[STAGE_EX]        = w_q[STAGE_ID];
    w_d[STAGE_MEM]       = w_q[STAGE_EX];
    w_d[STAGE_WB]        = w_q[STAGE_MEM];
  end

  // Per-slot controls. Priority is freeze > flush > stall > advance.
  // Reset is applied inside each slot.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path
    // through the block can leave a value unassigned and infer a latch.
    for (int s = 0; s < NUM_STAGES; s++) begin
      w_ctrl[s] = '{ld: 1'b1, hold: 1'b0, squash: 1'b0};
    end
    if (i_freeze) begin
      for (int s = 0; s < NUM_STAGES; s++) begin
        w_ctrl[s].hold = 1'b1;
      end
    end else if (i_flush) begin
      // ID holds a wrong-path instruction even under a stall, so squash it.
      w_ctrl[STAGE_ID].squash = 1'b1;
      w_ctrl[STAGE_EX].squash = 1'b1;
    end else if (i_stall) begin
      w_ctrl[STAGE_ID].hold   = 1'b1;
      w_ctrl[STAGE_EX].squash = 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_slot
    pipe_slot #(.NOP_WORD(NOP_WORD)) u_slot (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_ld     (w_ctrl[g].ld),
      .i_hold   (w_ctrl[g].hold),
      .i_squash (w_ctrl[g].squash),
      .i_d      (w_d[g]),
      .o_q      (w_q[g])
    );
  end

  // Counters sample the pre-edge WB slot. Retire and bubble counts therefore
  // always sum to the cycle count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cycle_cnt  <= '0;
      r_retire_cnt <= '0;
      r_bubble_cnt <= '0;
    end else if (!i_freeze) begin
      r_cycle_cnt  <= r_cycle_cnt + CNT_W'(1);
      r_retire_cnt <= r_retire_cnt + {{(CNT_W-1){1'b0}}, ~w_q[STAGE_WB].bubble};
      r_bubble_cnt <= r_bubble_cnt + {{(CNT_W-1){1'b0}}, w_q[STAGE_WB].bubble};
    end
  end

  assign o_id_inst    = w_q[STAGE_ID].inst;
  assign o_id_bubble  = w_q[STAGE_ID].bubble;
  assign o_ex_inst    = w_q[STAGE_EX].inst;
  assign o_ex_bubble  = w_q[STAGE_EX].bubble;
  assign o_mem_inst   = w_q[STAGE_MEM].inst;
  assign o_mem_bubble = w_q[STAGE_MEM].bubble;
  assign o_wb_inst    = w_q[STAGE_WB].inst;
  assign o_wb_bubble  = w_q[STAGE_WB].bubble;

  assign o_retire     = ~w_q[STAGE_WB].bubble & ~i_freeze & ~i_rst;

  assign o_cycle_cnt  = r_cycle_cnt;
  assign o_retire_cnt = r_retire_cnt;
  assign o_bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_track.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_track
//   Drives two copies of pipe_stage_track from the same inputs. One copy has
//   32-bit counters and the other has 4-bit counters. Every output is compared
//   against a reference model. The model keeps the four slots as a plain
//   array and shifts it according to the stage rules.
// ---------------------------------------------------------------------------
module tb_pipe_stage_track;

  logic        clk = 1'b0;
  logic        rst, if_valid, stall, flush, freeze;
  logic [31:0] if_inst;

  logic [31:0] id_inst, ex_inst, mem_inst, wb_inst;
  logic        id_bub, ex_bub, mem_bub, wb_bub, retire;
  logic [31:0] cyc, ret, bub;

  logic [31:0] id_inst4, ex_inst4, mem_inst4, wb_inst4;
  logic        id_bub4, ex_bub4, mem_bub4, wb_bub4, retire4;
  logic [3:0]  cyc4, ret4, bub4;

  always #5 clk = ~clk;

  pipe_stage_track #(.CNT_W(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_if_inst(if_inst), .i_if_valid(if_valid),
    .i_stall(stall), .i_flush(flush), .i_freeze(freeze),
    .o_id_inst(id_inst), .o_id_bubble(id_bub), .o_ex_inst(ex_inst), .o_ex_bubble(ex_bub),
    .o_mem_inst(mem_inst), .o_mem_bubble(mem_bub), .o_wb_inst(wb_inst), .o_wb_bubble(wb_bub),
    .o_retire(retire), .o_cycle_cnt(cyc), .o_retire_cnt(ret), .o_bubble_cnt(bub)
  );

  pipe_stage_track #(.CNT_W(4)) dut_w (
    .i_clk(clk), .i_rst(rst), .i_if_inst(if_inst), .i_if_valid(if_valid),
    .i_stall(stall), .i_flush(flush), .i_freeze(freeze),
    .o_id_inst(id_inst4), .o_id_bubble(id_bub4), .o_ex_inst(ex_inst4), .o_ex_bubble(ex_bub4),
    .o_mem_inst(mem_inst4), .o_mem_bubble(mem_bub4), .o_wb_inst(wb_inst4), .o_wb_bubble(wb_bub4),
    .o_retire(retire4), .o_cycle_cnt(cyc4), .o_retire_cnt(ret4), .o_bubble_cnt(bub4)
  );

  // Reference model. Index 0 = ID ... 3 = WB.
  logic [31:0] m_inst [4];
  logic        m_bub  [4];
  int unsigned m_cyc, m_ret, m_bcnt;
  bit          m_known = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("id_inst",  id_inst,  m_inst[0]);
    check("id_bub",   {31'b0, id_bub},  {31'b0, m_bub[0]});
    check("ex_inst",  ex_inst,  m_inst[1]);
    check("ex_bub",   {31'b0, ex_bub},  {31'b0, m_bub[1]});
    check("mem_inst", mem_inst, m_inst[2]);
    check("mem_bub",  {31'b0, mem_bub}, {31'b0, m_bub[2]});
    check("wb_inst",  wb_inst,  m_inst[3]);
    check("wb_bub",   {31'b0, wb_bub},  {31'b0, m_bub[3]});
    check("cycle_cnt",  cyc, m_cyc);
    check("retire_cnt", ret, m_ret);
    check("bubble_cnt", bub, m_bcnt);
    check("w_wb_inst",  wb_inst4, m_inst[3]);
    check("w_cycle_cnt",  {28'b0, cyc4}, m_cyc  % 16);
    check("w_retire_cnt", {28'b0, ret4}, m_ret  % 16);
    check("w_bubble_cnt", {28'b0, bub4}, m_bcnt % 16);
  endtask

  // Drive one cycle: set inputs, check combinational retire, clock, advance
  // the model, then check every registered output.
  task automatic step(input logic r, input logic [31:0] inst, input logic v,
                      input logic st, input logic fl, input logic fr);
    logic exp_ret;
    rst = r; if_inst = inst; if_valid = v; stall = st; flush = fl; freeze = fr;
    #1;
    if (m_known) begin
      exp_ret = !m_bub[3] && !fr && !r;
      check("retire",   {31'b0, retire},  {31'b0, exp_ret});
      check("w_retire", {31'b0, retire4}, {31'b0, exp_ret});
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 4; i++) begin m_inst[i] = 32'h0; m_bub[i] = 1'b1; end
      m_cyc = 0; m_ret = 0; m_bcnt = 0;
      m_known = 1'b1;
    end else if (!fr) begin
      m_cyc++;
      if (m_bub[3]) m_bcnt++; else m_ret++;
      m_inst[3] = m_inst[2]; m_bub[3] = m_bub[2];
      m_inst[2] = m_inst[1]; m_bub[2] = m_bub[1];
      if (fl) begin
        m_inst[1] = 32'h0; m_bub[1] = 1'b1;
        m_inst[0] = 32'h0; m_bub[0] = 1'b1;
      end else if (st) begin
        m_inst[1] = 32'h0; m_bub[1] = 1'b1;
      end else begin
        m_inst[1] = m_inst[0]; m_bub[1] = m_bub[0];
        m_inst[0] = v ? inst : 32'h0; m_bub[0] = !v;
      end
    end
    #1;
    if (m_known) check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  localparam logic [31:0] A = 32'hA000_000A;
  localparam logic [31:0] B = 32'hB000_000B;
  localparam logic [31:0] C = 32'hC000_000C;
  localparam logic [31:0] D = 32'hD000_000D;

  initial begin
    logic fr_st, fr_fl;

    // Reset held for two cycles, with stall/freeze asserted to show that reset wins.
    step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_wb_bub",  {31'b0, wb_bub}, 32'd1);
    check("rst_id_inst", id_inst, 32'h0);
    check("rst_cycle",   cyc, 32'd0);

    // Flow: the first word reaches WB on the 4th edge. After 7 edges, 3 have retired.
    step(1'b0, 32'h2008_0005, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h2009_0003, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0109_5020, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0); // invalid word must become NOP
    check("flow_wb_edge4", wb_inst, 32'h2008_0005);
    check("flow_id_nop",   id_inst, 32'h0);
    idle(3);
    check("flow_retire_cnt", ret, 32'd3);
    check("flow_bubble_cnt", bub, 32'd4);
    check("flow_cycle_cnt",  cyc, 32'd7);

    // Stall: ID keeps A, EX gets a bubble, then A moves on and B enters ID.
    step(1'b0, A, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, B, 1'b1, 1'b1, 1'b0, 1'b0);
    check("stall_id_hold", id_inst, A);
    check("stall_ex_bub",  {31'b0, ex_bub}, 32'd1);
    step(1'b0, B, 1'b1, 1'b0, 1'b0, 1'b0);
    check("stall_ex_a", ex_inst, A);
    check("stall_id_b", id_inst, B);
    idle(4);

    // Flush: first alone, then together with stall. Both squash A and C.
    for (int k = 0; k < 2; k++) begin
      step(1'b0, A, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, C, 1'b1, k[0], 1'b1, 1'b0);
      check("flush_id_bub", {31'b0, id_bub}, 32'd1);
      check("flush_ex_bub", {31'b0, ex_bub}, 32'd1);
      step(1'b0, D, 1'b1, 1'b0, 1'b0, 1'b0);
      check("flush_id_d", id_inst, D);
      idle(4);
    end

    // Freeze mid-stream with stall/flush toggling underneath.
    step(1'b0, A, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, B, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      fr_st = 1'($urandom); fr_fl = 1'($urandom);
      step(1'b0, $urandom, 1'($urandom), fr_st, fr_fl, 1'b1);
    end
    check("freeze_id_b", id_inst, B);
    step(1'b0, C, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);

    // Wrap: 17 valid instructions after reset; the 4-bit counters pass 15->0.
    step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) step(1'b0, 32'h100 + i, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(5);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 2,  $urandom, $urandom_range(0, 99) < 80,
           $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10,
           $urandom_range(0, 99) < 10);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
